// File: rtl/bus_cycle_gen.sv
// rtl/bus_cycle_gen.sv - multiplexed address/data bus cycle generator for the external RTC
module bus_cycle_gen #(
  parameter int DATA_W   = 8,
  parameter int T_ADDR   = 2,
  parameter int T_GAP    = 2,
  parameter int T_STROBE = 4,
  parameter int T_REC    = 2,
  parameter int CNT_W    = 4
) (
  input  logic              clkAD,
  input  logic              resetAD,
  input  logic              start,
  input  logic              rw,
  input  logic [DATA_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] bus_in,
  output logic [DATA_W-1:0] bus_out,
  output logic              dir,
  output logic              cs_n,
  output logic              rd_n,
  output logic              wr_n,
  output logic              ad,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata
);

  typedef enum logic [2:0] {IDLE, ADDR, GAP, DATA, REC} stateT;

  typedef struct packed {
    logic              csN;
    logic              rdN;
    logic              wrN;
    logic              adSel;
    logic              drive;
    logic [DATA_W-1:0] data;
  } pinsT;

  localparam logic [CNT_W-1:0] LAST_ADDR   = CNT_W'(T_ADDR - 1);
  localparam logic [CNT_W-1:0] LAST_GAP    = CNT_W'(T_GAP - 1);
  localparam logic [CNT_W-1:0] LAST_STROBE = CNT_W'(T_STROBE - 1);
  localparam logic [CNT_W-1:0] LAST_REC    = CNT_W'(T_REC - 1);

  stateT             state;
  logic [CNT_W-1:0]  phaseCnt;
  logic              isRead;
  logic [DATA_W-1:0] wdataLat;
  pinsT              pins;

  // Pad and strobe levels for a phase; IDLE yields the released-bus values.
  // During a write the data stays on the bus from GAP through REC for setup and hold.
  function automatic pinsT phasePins(input stateT s, input logic rd,
                                     input logic [DATA_W-1:0] a,
                                     input logic [DATA_W-1:0] w);
    pinsT p;
    p.csN   = 1'b1;
    p.rdN   = 1'b1;
    p.wrN   = 1'b1;
    p.adSel = 1'b1;
    p.drive = 1'b0;
    p.data  = '0;
    case (s)
      ADDR: begin
        p.csN   = 1'b0;
        p.wrN   = 1'b0;
        p.adSel = 1'b0;
        p.drive = 1'b1;
        p.data  = a;
      end
      GAP, REC: begin
        p.drive = !rd;
        p.data  = rd ? '0 : w;
      end
      DATA: begin
        p.csN   = 1'b0;
        p.rdN   = !rd;
        p.wrN   = rd;
        p.drive = !rd;
        p.data  = rd ? '0 : w;
      end
      default: ;
    endcase
    return p;
  endfunction

  assign cs_n    = pins.csN;
  assign rd_n    = pins.rdN;
  assign wr_n    = pins.wrN;
  assign ad      = pins.adSel;
  assign dir     = pins.drive;
  assign bus_out = pins.data;

  // Phase sequencer; pin levels are computed for the state being entered so every output is a flop.
  always_ff @(posedge clkAD) begin
    if (!resetAD) begin
      state    <= IDLE;
      phaseCnt <= '0;
      isRead   <= 1'b0;
      wdataLat <= '0;
      pins     <= phasePins(IDLE, 1'b0, '0, '0);
      busy     <= 1'b0;
      done     <= 1'b0;
      rdata    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            isRead   <= rw;
            wdataLat <= wdata;
            state    <= ADDR;
            phaseCnt <= '0;
            pins     <= phasePins(ADDR, rw, addr, wdata);
            busy     <= 1'b1;
          end
        end
        ADDR: begin
          if (phaseCnt == LAST_ADDR) begin
            state    <= GAP;
            phaseCnt <= '0;
            pins     <= phasePins(GAP, isRead, '0, wdataLat);
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        GAP: begin
          if (phaseCnt == LAST_GAP) begin
            state    <= DATA;
            phaseCnt <= '0;
            pins     <= phasePins(DATA, isRead, '0, wdataLat);
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        DATA: begin
          if (phaseCnt == LAST_STROBE) begin
            state    <= REC;
            phaseCnt <= '0;
            pins     <= phasePins(REC, isRead, '0, wdataLat);
            if (isRead) begin
              rdata <= bus_in;
            end
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        REC: begin
          if (phaseCnt == LAST_REC) begin
            state    <= IDLE;
            phaseCnt <= '0;
            pins     <= phasePins(IDLE, 1'b0, '0, '0);
            busy     <= 1'b0;
            done     <= 1'b1;
          end else begin
            phaseCnt <= phaseCnt + 1'b1;
          end
        end
        default: begin
          state    <= IDLE;
          phaseCnt <= '0;
          pins     <= phasePins(IDLE, 1'b0, '0, '0);
          busy     <= 1'b0;
        end
      endcase
    end
  end

endmodule
